// File: rtl/pengo_input_pkg.sv
// Shared constants for the pengo input conditioning stage:
// PS/2 scan codes, joystick bit indices and in0/in1 bit positions.
package pengo_input_pkg;

  // Arrow codes are compared on [7:0] only, so E0-prefixed and keypad variants both hit
  localparam logic [7:0] PS2_UP    = 8'h75;
  localparam logic [7:0] PS2_DOWN  = 8'h72;
  localparam logic [7:0] PS2_LEFT  = 8'h6B;
  localparam logic [7:0] PS2_RIGHT = 8'h74;

  localparam logic [8:0] PS2_FIRE1_A  = 9'h029;
  localparam logic [8:0] PS2_FIRE1_B  = 9'h014;
  localparam logic [8:0] PS2_START1_A = 9'h005;
  localparam logic [8:0] PS2_START1_B = 9'h016;
  localparam logic [8:0] PS2_START2_A = 9'h006;
  localparam logic [8:0] PS2_START2_B = 9'h01E;
  localparam logic [8:0] PS2_COIN1    = 9'h02E;
  localparam logic [8:0] PS2_COIN2    = 9'h036;
  localparam logic [8:0] PS2_UP2      = 9'h02D;
  localparam logic [8:0] PS2_DOWN2    = 9'h02B;
  localparam logic [8:0] PS2_LEFT2    = 9'h023;
  localparam logic [8:0] PS2_RIGHT2   = 9'h034;
  localparam logic [8:0] PS2_FIRE2    = 9'h01C;

  localparam int JOY_R      = 0;
  localparam int JOY_L      = 1;
  localparam int JOY_D      = 2;
  localparam int JOY_U      = 3;
  localparam int JOY_FIRE   = 4;
  localparam int JOY_START1 = 5;
  localparam int JOY_START2 = 6;
  localparam int JOY_COIN   = 7;

  localparam int IN0_UP    = 0;
  localparam int IN0_DOWN  = 1;
  localparam int IN0_LEFT  = 2;
  localparam int IN0_RIGHT = 3;
  localparam int IN0_COIN2 = 4;
  localparam int IN0_COIN1 = 5;
  localparam int IN0_FIXED = 6;
  localparam int IN0_FIRE  = 7;

  localparam int IN1_UP     = 0;
  localparam int IN1_DOWN   = 1;
  localparam int IN1_LEFT   = 2;
  localparam int IN1_RIGHT  = 3;
  localparam int IN1_FIXED  = 4;
  localparam int IN1_START1 = 5;
  localparam int IN1_START2 = 6;
  localparam int IN1_FIRE   = 7;

  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
    logic fire;
  } pad_t;

endpackage

// File: rtl/pengo_coin_stretch.sv
// Holds a coin input asserted for at least COIN_FRAMES vblank rising edges
// after each raw rising edge; a new press reloads the count.
module pengo_coin_stretch #(
  parameter int COIN_FRAMES = 4
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic raw,
  input  logic vblank_rise,
  output logic out
);

  logic       raw_q;
  logic [3:0] cnt;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      raw_q <= 1'b0;
      cnt   <= '0;
    end else begin
      raw_q <= raw;
      // reload takes priority over a coincident frame decrement
      if (raw && !raw_q)
        cnt <= 4'(COIN_FRAMES);
      else if (vblank_rise && cnt != '0)
        cnt <= cnt - 4'd1;
    end
  end

  assign out = raw | (cnt != '0);

endmodule

// File: rtl/pengo_input_ctrl.sv
// Input conditioning ahead of the pengo core: PS/2 key state, joystick merge,
// opposing-direction cleanup, coin stretching, registered active-low in0/in1.
module pengo_input_ctrl
  import pengo_input_pkg::*;
#(
  parameter int COIN_FRAMES = 4,
  parameter int SOCD_CLEAN  = 1
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  input  logic        vblank,
  output logic [7:0]  in0,
  output logic [7:0]  in1
);

  localparam logic SOCD = (SOCD_CLEAN != 0);

  logic       toggle_q, vblank_q;
  pad_t       key_p1, key_p2;
  logic       key_start1, key_start2, key_coin1, key_coin2;
  logic       key_evt, pressed, vblank_rise;
  logic [8:0] code;

  assign key_evt     = ps2_key[10] ^ toggle_q;
  assign pressed     = ps2_key[9];
  assign code        = ps2_key[8:0];
  assign vblank_rise = vblank & ~vblank_q;

  always_ff @(posedge clk_sys) begin
    toggle_q <= ps2_key[10];
    vblank_q <= vblank;
    if (!reset_n) begin
      key_p1     <= '0;
      key_p2     <= '0;
      key_start1 <= 1'b0;
      key_start2 <= 1'b0;
      key_coin1  <= 1'b0;
      key_coin2  <= 1'b0;
    end else if (key_evt) begin
      if (code[7:0] == PS2_UP)    key_p1.up    <= pressed;
      if (code[7:0] == PS2_DOWN)  key_p1.down  <= pressed;
      if (code[7:0] == PS2_LEFT)  key_p1.left  <= pressed;
      if (code[7:0] == PS2_RIGHT) key_p1.right <= pressed;
      case (code)
        PS2_FIRE1_A, PS2_FIRE1_B:   key_p1.fire  <= pressed;
        PS2_START1_A, PS2_START1_B: key_start1   <= pressed;
        PS2_START2_A, PS2_START2_B: key_start2   <= pressed;
        PS2_COIN1:                  key_coin1    <= pressed;
        PS2_COIN2:                  key_coin2    <= pressed;
        PS2_UP2:                    key_p2.up    <= pressed;
        PS2_DOWN2:                  key_p2.down  <= pressed;
        PS2_LEFT2:                  key_p2.left  <= pressed;
        PS2_RIGHT2:                 key_p2.right <= pressed;
        PS2_FIRE2:                  key_p2.fire  <= pressed;
        default: ;
      endcase
    end
  end

  pad_t raw_p1, raw_p2, p1, p2;
  logic start1, start2, coin1_raw, coin2_raw, coin1, coin2;

  always_comb begin
    raw_p1.up    = key_p1.up    | joystick_0[JOY_U];
    raw_p1.down  = key_p1.down  | joystick_0[JOY_D];
    raw_p1.left  = key_p1.left  | joystick_0[JOY_L];
    raw_p1.right = key_p1.right | joystick_0[JOY_R];
    raw_p1.fire  = key_p1.fire  | joystick_0[JOY_FIRE];
    raw_p2.up    = key_p2.up    | joystick_1[JOY_U];
    raw_p2.down  = key_p2.down  | joystick_1[JOY_D];
    raw_p2.left  = key_p2.left  | joystick_1[JOY_L];
    raw_p2.right = key_p2.right | joystick_1[JOY_R];
    raw_p2.fire  = key_p2.fire  | joystick_1[JOY_FIRE];
    start1    = key_start1 | joystick_0[JOY_START1] | joystick_1[JOY_START1];
    start2    = key_start2 | joystick_0[JOY_START2] | joystick_1[JOY_START2];
    coin1_raw = key_coin1 | joystick_0[JOY_COIN];
    coin2_raw = key_coin2 | joystick_1[JOY_COIN];

    // opposing directions held together cancel to neither
    p1 = raw_p1;
    p2 = raw_p2;
    p1.up    = raw_p1.up    & ~(SOCD & raw_p1.down);
    p1.down  = raw_p1.down  & ~(SOCD & raw_p1.up);
    p1.left  = raw_p1.left  & ~(SOCD & raw_p1.right);
    p1.right = raw_p1.right & ~(SOCD & raw_p1.left);
    p2.up    = raw_p2.up    & ~(SOCD & raw_p2.down);
    p2.down  = raw_p2.down  & ~(SOCD & raw_p2.up);
    p2.left  = raw_p2.left  & ~(SOCD & raw_p2.right);
    p2.right = raw_p2.right & ~(SOCD & raw_p2.left);
  end

  pengo_coin_stretch #(.COIN_FRAMES(COIN_FRAMES)) u_coin1 (
    .clk_sys(clk_sys), .reset_n(reset_n), .raw(coin1_raw),
    .vblank_rise(vblank_rise), .out(coin1)
  );

  pengo_coin_stretch #(.COIN_FRAMES(COIN_FRAMES)) u_coin2 (
    .clk_sys(clk_sys), .reset_n(reset_n), .raw(coin2_raw),
    .vblank_rise(vblank_rise), .out(coin2)
  );

  logic [7:0] act0, act1;

  always_comb begin
    act0 = '0;
    act0[IN0_UP]    = p1.up;
    act0[IN0_DOWN]  = p1.down;
    act0[IN0_LEFT]  = p1.left;
    act0[IN0_RIGHT] = p1.right;
    act0[IN0_COIN2] = coin2;
    act0[IN0_COIN1] = coin1;
    act0[IN0_FIRE]  = p1.fire;
    act1 = '0;
    act1[IN1_UP]     = p2.up;
    act1[IN1_DOWN]   = p2.down;
    act1[IN1_LEFT]   = p2.left;
    act1[IN1_RIGHT]  = p2.right;
    act1[IN1_START1] = start1;
    act1[IN1_START2] = start2;
    act1[IN1_FIRE]   = p2.fire;
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      in0 <= 8'hFF;
      in1 <= 8'hFF;
    end else begin
      in0 <= ~act0;
      in1 <= ~act1;
    end
  end

endmodule
